cpu_bus_arbiter: RTL and testbench
==================================

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter ALIGN_EN, default 1, meaning insert one alignment cycle so a DMA transfer starts on a get cycle.
REQ-002 SHALL have port clk  in  1  system clock, one CPU bus cycle per rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_addr  in  16, cpu_wdata  in  8, cpu_we  in  1 (high = write): the CPU's bus request.
REQ-005 SHALL have ports oam_req  in  1, oam_addr  in  16, oam_wdata  in  8, oam_we  in  1: the OAM DMA request and transfer.
REQ-006 SHALL have ports dmc_req  in  1 (single-byte sample fetch) and dmc_addr  in  16.
REQ-007 SHALL have outputs bus_addr  out  16, bus_wdata  out  8, bus_we  out  1: the muxed system bus.
REQ-008 SHALL have outputs cpu_rdy  out  1 (low stalls the CPU), oam_gnt  out  1 and dmc_ack  out  1 (high for exactly the cycle the DMC read is on the bus).

Function
REQ-009 SHALL keep a parity flop that toggles every clk: parity 0 = get cycle, parity 1 = put cycle.
REQ-010 SHALL implement states CPU, HALT, ALIGN, OAM and DMC, held in a registered state with next-state logic separate.
REQ-011 In CPU, on (oam_req | dmc_req) & ~cpu_we, SHALL go to HALT next cycle; with cpu_we=1 it SHALL stay in CPU, because the CPU halts only on reads.
REQ-012 HALT SHALL last exactly 1 cycle with the CPU address still driven and bus_we=0 (dummy read).
REQ-013 After HALT SHALL go to DMC if dmc_req and parity=0; else to ALIGN if ALIGN_EN and parity=1; else to OAM if oam_req; else to CPU.
REQ-014 ALIGN SHALL last 1 cycle (bus_we=0, CPU address driven), then apply the REQ-013 selection minus HALT.
REQ-015 DMC SHALL last 1 cycle: bus_addr=dmc_addr, bus_we=0, dmc_ack=1. Next state SHALL be OAM if oam_req, else CPU.
REQ-016 OAM SHALL drive bus_addr/bus_wdata/bus_we from oam_* with oam_gnt=1.
REQ-017 In OAM, if dmc_req=1 and parity=0, SHALL go to DMC next cycle (steal one get cycle). oam_gnt=0 during the DMC cycle; the DMA unit holds its position.
REQ-018 In OAM, when oam_req=0, SHALL go to CPU next cycle.
REQ-019 cpu_rdy SHALL be 1 only in state CPU; it is decoded from the state flop, never from request inputs.
REQ-020 In CPU, HALT and ALIGN the bus SHALL carry cpu_addr/cpu_wdata, with bus_we=cpu_we in CPU and 0 otherwise.
REQ-021 With simultaneous dmc_req and oam_req, DMC SHALL win; OAM is never starved beyond 1 cycle per DMC request.
REQ-022 A dmc_req withdrawn before DMC is entered SHALL be dropped with no dmc_ack.
REQ-023 oam_gnt and dmc_ack SHALL never both be 1; exactly one owner drives bus_we in any cycle.

Reset
REQ-024 On reset: state=CPU, parity=0, cpu_rdy=1, oam_gnt=0, dmc_ack=0, bus mux selecting CPU. Asserting reset mid-transfer SHALL abandon the transfer immediately.
REQ-025 After reset release the first edge SHALL be a get cycle (parity=0).

Structure
REQ-026 The state enum and the owner encoding SHALL live in shared package nes_bus_pkg, also used by the OAM DMA and the APU DMC.
REQ-027 The bus mux SHALL be a sub-module bus_mux: combinational, selected by owner.

Verification
REQ-028 Reset mid-OAM: cpu_rdy=1 and oam_gnt=0 immediately; parity=0 at release.
REQ-029 oam_req rises with cpu_we=0 at parity=0 -> HALT, ALIGN, then oam_gnt=1; cpu_rdy low from the following cycle; 256-pair transfer, then oam_req=0 -> CPU with cpu_rdy=1 one cycle later.
REQ-030 oam_req while cpu_we=1 for 2 cycles (write burst) -> stays in CPU until cpu_we=0, then HALT.
REQ-031 dmc_req during OAM at parity=1 -> waits 1 cycle; next get cycle dmc_ack=1, bus_addr=dmc_addr (e.g. 16'hC040), oam_gnt=0; OAM resumes next cycle.
REQ-032 dmc_req and oam_req rise together from CPU -> DMC served first (dmc_ack once), then OAM; oam_gnt and dmc_ack are never both 1.
REQ-033 dmc_req pulses 1 cycle then drops during HALT -> no dmc_ack; returns to CPU (or OAM if oam_req).

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: arbiter state codes, bus owner encoding
// and the DMA start selection used by the CPU arbiter, OAM DMA and APU DMC.
package nes_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_CPU   = 3'd0;
    localparam state_t ST_HALT  = 3'd1;
    localparam state_t ST_ALIGN = 3'd2;
    localparam state_t ST_OAM   = 3'd3;
    localparam state_t ST_DMC   = 3'd4;

    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_OAM = 2'd1,
        OWN_DMC = 2'd2
    } owner_t;

    // Pick the first DMA cycle after the CPU has been halted. DMC has
    // priority on get cycles; a put cycle may burn one alignment cycle.
    function automatic state_t dma_select(input logic dmc_req,
                                          input logic oam_req,
                                          input logic parity,
                                          input logic align_ok);
        if (dmc_req && !parity)
            return ST_DMC;
        else if (align_ok && parity)
            return ST_ALIGN;
        else if (oam_req)
            return ST_OAM;
        else
            return ST_CPU;
    endfunction

    // Which requester owns the address/data/we lines in a given state.
    function automatic owner_t state_owner(input state_t st);
        case (st)
            ST_OAM:  return OWN_OAM;
            ST_DMC:  return OWN_DMC;
            default: return OWN_CPU;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Request/grant and muxed system-bus signals between the CPU, the two DMA
// engines and the arbiter. The arbiter drives the bus (master modport).
interface cpu_bus_arbiter_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;

    logic        oam_req;
    logic [15:0] oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;

    logic        dmc_req;
    logic [15:0] dmc_addr;

    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;

    logic        cpu_rdy;
    logic        oam_gnt;
    logic        dmc_ack;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_we,
        input  oam_req, oam_addr, oam_wdata, oam_we,
        input  dmc_req, dmc_addr,
        output bus_addr, bus_wdata, bus_we,
        output cpu_rdy, oam_gnt, dmc_ack
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_we,
        output oam_req, oam_addr, oam_wdata, oam_we,
        output dmc_req, dmc_addr,
        input  bus_addr, bus_wdata, bus_we,
        input  cpu_rdy, oam_gnt, dmc_ack
    );

endinterface

// File: rtl/cpu_bus_arbiter_bus_mux.sv
// Combinational system-bus multiplexer selected by the current owner.
module bus_mux
    import nes_bus_pkg::*;
(
    input  owner_t      i_owner,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_cpu_we,
    input  logic [15:0] i_oam_addr,
    input  logic [7:0]  i_oam_wdata,
    input  logic        i_oam_we,
    input  logic [15:0] i_dmc_addr,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    output logic        o_bus_we
);

    // Route the selected owner onto the bus; DMC is always a read.
    always_comb begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wdata = i_cpu_wdata;
        o_bus_we    = i_cpu_we;
        case (i_owner)
            OWN_OAM: begin
                o_bus_addr  = i_oam_addr;
                o_bus_wdata = i_oam_wdata;
                o_bus_we    = i_oam_we;
            end
            OWN_DMC: begin
                o_bus_addr  = i_dmc_addr;
                o_bus_wdata = 8'h00;
                o_bus_we    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// NES CPU bus arbiter: halts the CPU on a read cycle and hands the bus to
// OAM DMA or the DMC sample fetch, keeping DMA aligned to get/put parity.
module cpu_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic ALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    cpu_bus_arbiter_if.master bus
);

    state_t      r_state;
    state_t      w_next;
    logic        r_parity;      // 0 = get cycle, 1 = put cycle
    owner_t      w_owner;
    logic        w_cpu_we;
    logic [15:0] w_bus_addr;
    logic [7:0]  w_bus_wdata;
    logic        w_bus_we;

    // Get/put parity; cleared by reset so the first edge after release is a get.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_parity <= 1'b0;
        else
            r_parity <= ~r_parity;
    end

    // Arbiter state register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_CPU;
        else
            r_state <= w_next;
    end

    // Next-state selection. The CPU can only be halted on a read cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CPU: begin
                if ((bus.oam_req | bus.dmc_req) & ~bus.cpu_we)
                    w_next = ST_HALT;
            end
            ST_HALT:
                w_next = dma_select(bus.dmc_req, bus.oam_req, r_parity, ALIGN_EN);
            ST_ALIGN:
                w_next = dma_select(bus.dmc_req, bus.oam_req, r_parity, 1'b0);
            ST_DMC:
                w_next = bus.oam_req ? ST_OAM : ST_CPU;
            ST_OAM: begin
                if (bus.dmc_req && !r_parity)
                    w_next = ST_DMC;        // steal one get cycle from OAM
                else if (!bus.oam_req)
                    w_next = ST_CPU;
            end
            default:
                w_next = ST_CPU;
        endcase
    end

    // Owner and status decode come from the state flop only.
    assign w_owner  = state_owner(r_state);
    assign w_cpu_we = bus.cpu_we & (r_state == ST_CPU);

    bus_mux u_bus_mux (
        .i_owner     (w_owner),
        .i_cpu_addr  (bus.cpu_addr),
        .i_cpu_wdata (bus.cpu_wdata),
        .i_cpu_we    (w_cpu_we),
        .i_oam_addr  (bus.oam_addr),
        .i_oam_wdata (bus.oam_wdata),
        .i_oam_we    (bus.oam_we),
        .i_dmc_addr  (bus.dmc_addr),
        .o_bus_addr  (w_bus_addr),
        .o_bus_wdata (w_bus_wdata),
        .o_bus_we    (w_bus_we)
    );

    assign bus.bus_addr  = w_bus_addr;
    assign bus.bus_wdata = w_bus_wdata;
    assign bus.bus_we    = w_bus_we;
    assign bus.cpu_rdy   = (r_state == ST_CPU);
    assign bus.oam_gnt   = (r_state == ST_OAM);
    assign bus.dmc_ack   = (r_state == ST_DMC);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: a vector table walking the main
// arbitration paths from reset, a full 256-pair OAM transfer, and a reset
// abandoning an OAM transfer followed by a parity probe.
module tb_cpu_bus_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cpu_bus_arbiter_if bif();

    cpu_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    localparam logic [15:0] CA = 16'h1234;
    localparam logic [15:0] OA = 16'h2004;
    localparam logic [15:0] DA = 16'hC040;
    localparam logic [7:0]  CD = 8'h5A;
    localparam logic [7:0]  OD = 8'hA5;

    // inputs: oreq dreq cwe owe ; expected: rdy gnt ack we sel(0 cpu,1 oam,2 dmc)
    typedef struct {
        logic       oreq, dreq, cwe, owe;
        logic       rdy, gnt, ack, we;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic add(input logic oq, input logic dq, input logic cw, input logic ow,
                       input logic rd, input logic gn, input logic ak, input logic we,
                       input logic [1:0] sl);
        vec_t v;
        v.oreq = oq; v.dreq = dq; v.cwe = cw; v.owe = ow;
        v.rdy = rd; v.gnt = gn; v.ack = ak; v.we = we; v.sel = sl;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic oq, input logic dq, input logic cw, input logic ow);
        bif.oam_req = oq;
        bif.dmc_req = dq;
        bif.cpu_we  = cw;
        bif.oam_we  = ow;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {rdy,gnt,ack,we,addr,wdata}; wdata is not meaningful on a DMC read.
    function automatic logic [27:0] obs();
        logic [7:0] wd;
        wd = bif.dmc_ack ? 8'h00 : bif.bus_wdata;
        return {bif.cpu_rdy, bif.oam_gnt, bif.dmc_ack, bif.bus_we, bif.bus_addr, wd};
    endfunction

    function automatic logic [27:0] mkexp(input logic rd, input logic gn, input logic ak,
                                          input logic we, input logic [1:0] sl);
        logic [15:0] a;
        logic [7:0]  d;
        a = (sl == 2'd1) ? OA : (sl == 2'd2) ? DA : CA;
        d = (sl == 2'd1) ? OD : (sl == 2'd2) ? 8'h00 : CD;
        return {rd, gn, ak, we, a, d};
    endfunction

    task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got rdy/gnt/ack/we/addr/wdata=%h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        bif.cpu_addr  = CA;
        bif.cpu_wdata = CD;
        bif.oam_addr  = OA;
        bif.oam_wdata = OD;
        bif.dmc_addr  = DA;
        drive(0, 0, 0, 0);

        //   oq dq cw ow   rd gn ak we sel
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);  // idle CPU read, get cycle
        add(0, 0, 1, 0,   1, 0, 0, 1, 0);  // CPU write passes through
        add(1, 0, 1, 0,   1, 0, 0, 1, 0);  // OAM req during write burst: no halt
        add(1, 0, 1, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0,   1, 0, 0, 0, 0);  // first read -> HALT next
        add(1, 0, 1, 0,   0, 0, 0, 0, 0);  // HALT: dummy read, we forced 0
        add(1, 0, 1, 0,   0, 0, 0, 0, 0);  // ALIGN
        add(1, 1, 0, 0,   0, 1, 0, 0, 1);  // OAM put cycle, DMC arrives: waits
        add(1, 1, 0, 1,   0, 1, 0, 1, 1);  // OAM get cycle -> DMC next
        add(1, 1, 0, 1,   0, 0, 1, 0, 2);  // DMC steal, oam_gnt low
        add(1, 0, 0, 0,   0, 1, 0, 0, 1);  // OAM resumes
        add(0, 0, 0, 1,   0, 1, 0, 1, 1);  // oam_req drops -> CPU next
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 0, 0, 0);  // both rise together
        add(1, 1, 0, 0,   0, 0, 0, 0, 0);  // HALT on get -> DMC first
        add(1, 1, 0, 0,   0, 0, 1, 0, 2);  // DMC served
        add(1, 0, 0, 1,   0, 1, 0, 1, 1);  // then OAM
        add(0, 0, 0, 0,   0, 1, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 0, 1, 0);
        add(0, 1, 0, 0,   1, 0, 0, 0, 0);  // 1-cycle DMC pulse
        add(0, 0, 0, 0,   0, 0, 0, 0, 0);  // HALT: request gone, dropped
        add(0, 0, 0, 0,   1, 0, 0, 0, 0);  // back in CPU, no ack seen

        #2;
        check("reset_state", obs(), mkexp(1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (i > 0) step();
            drive(tbl[i].oreq, tbl[i].dreq, tbl[i].cwe, tbl[i].owe);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(),
                  mkexp(tbl[i].rdy, tbl[i].gnt, tbl[i].ack, tbl[i].we, tbl[i].sel));
        end

        // Full 256-pair OAM transfer starting from a get-cycle request.
        step();
        drive(1, 0, 0, 0);
        @(negedge clk);
        check("xfer_req", obs(), mkexp(1, 0, 0, 0, 0));
        step();
        @(negedge clk);
        check("xfer_halt", obs(), mkexp(0, 0, 0, 0, 0));
        step();
        @(negedge clk);
        check("xfer_align", obs(), mkexp(0, 0, 0, 0, 0));
        for (int k = 0; k < 512; k++) begin
            logic [15:0] a;
            logic [7:0]  d;
            step();
            a = k[0] ? 16'h2004 : (16'h0200 + 16'(k >> 1));
            d = 8'(k >> 1);
            bif.oam_addr  = a;
            bif.oam_wdata = d;
            drive((k != 511), 0, 0, k[0]);
            @(negedge clk);
            check($sformatf("xfer%0d", k), obs(), {1'b0, 1'b1, 1'b0, k[0], a, d});
        end
        step();
        bif.oam_addr  = OA;
        bif.oam_wdata = OD;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("xfer_done", obs(), mkexp(1, 0, 0, 0, 0));

        // Reset in the middle of an OAM transfer.
        step();
        drive(1, 0, 0, 0);
        step();
        step();
        step();
        @(negedge clk);
        check("pre_reset_oam", obs(), mkexp(0, 1, 0, 0, 1));
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_oam", obs(), mkexp(1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1, 0, 0);
        @(negedge clk);
        check("post_reset_cpu", obs(), mkexp(1, 0, 0, 0, 0));
        // Get cycle at release puts HALT on a put cycle, so ALIGN precedes DMC.
        step();
        @(negedge clk);
        check("post_reset_halt", obs(), mkexp(0, 0, 0, 0, 0));
        step();
        @(negedge clk);
        check("post_reset_align", obs(), mkexp(0, 0, 0, 0, 0));
        step();
        @(negedge clk);
        check("post_reset_dmc", obs(), mkexp(0, 0, 1, 0, 2));
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_back", obs(), mkexp(1, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
